// File: rtl/dragonfang_pkg.sv
// Shared types for the vector write-back path: data packets, write-back control,
// the pipeline entry and the write-back stage occupancy encoding.
package dragonfang_pkg;

   localparam int unsigned DEFAULT_VREG_ADDRESS_WIDTH = 5;
   localparam int unsigned DATA_WIDTH                 = 64;
   localparam int unsigned TAG_WIDTH                  = 8;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } data_packet_t;

   typedef struct packed {
      logic [1:0] bit_mode;
      logic       vm;
      logic       vta;
      logic       vma;
   } write_back_vector_t;

   typedef struct packed {
      data_packet_t                          vd_new;
      write_back_vector_t                    control;
      logic [DEFAULT_VREG_ADDRESS_WIDTH-1:0] address;
   } write_back_entry_t;

   typedef enum logic [1:0] {
      StEmpty,
      StROnly,
      StWOnly,
      StBoth
   } wb_state_e;

endpackage

// File: rtl/vector_write_back_hazard_detect.sv
// Flags read-after-write conflicts between the entry reading in stage R and the
// entry writing in stage W during the same cycle.
module vector_write_back_hazard_detect
   import dragonfang_pkg::*;
#(
   parameter int unsigned VREG_ADDRESS_WIDTH = DEFAULT_VREG_ADDRESS_WIDTH
) (
   input  logic                          i_r_valid,
   input  logic [VREG_ADDRESS_WIDTH-1:0] i_r_address,
   input  logic                          i_w_valid,
   input  logic [VREG_ADDRESS_WIDTH-1:0] i_w_address,
   output logic                          o_vd_hazard,
   output logic                          o_v0_hazard
);

   logic w_both_valid;

   assign w_both_valid = i_r_valid & i_w_valid;
   assign o_vd_hazard  = w_both_valid & (i_r_address == i_w_address);
   // v0 is fetched alongside every vd_old read, so any write to index 0 conflicts.
   assign o_v0_hazard  = w_both_valid & (i_w_address == '0);

endmodule

// File: rtl/vector_write_back_controller.sv
// Two-stage (read, write) vector write-back controller. Define
// WRITE_BACK_FORWARDING_EN to forward on RAW hazards instead of stalling stage R.
module vector_write_back_controller
   import dragonfang_pkg::*;
#(
   parameter int unsigned VREG_ADDRESS_WIDTH = DEFAULT_VREG_ADDRESS_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          execute_valid,
   output logic                          execute_ready,
   input  data_packet_t                  execute_vd_new,
   input  write_back_vector_t            execute_control,
   input  logic [VREG_ADDRESS_WIDTH-1:0] execute_vd_address,
   output logic                          rf_read_enable,
   output logic [VREG_ADDRESS_WIDTH-1:0] rf_read_address,
   input  data_packet_t                  rf_read_vd_old,
   input  data_packet_t                  rf_read_v0,
   output write_back_vector_t            mask_control,
   output data_packet_t                  mask_v0,
   output data_packet_t                  mask_vd_old,
   output data_packet_t                  mask_vd_new,
   input  data_packet_t                  mask_vd,
   output logic                          rf_write_enable,
   output logic [VREG_ADDRESS_WIDTH-1:0] rf_write_address,
   output data_packet_t                  rf_write_data
);

   wb_state_e         r_state;
   write_back_entry_t r_r_entry;
   write_back_entry_t r_w_entry;

   logic                          w_r_valid;
   logic                          w_w_valid;
   logic                          w_r_valid_next;
   logic                          w_vd_hazard;
   logic                          w_v0_hazard;
   logic                          w_stall;
   logic                          w_advance;
   logic                          w_accept;
   logic                          w_r_active;
   logic                          w_w_active;
   logic [VREG_ADDRESS_WIDTH-1:0] w_r_address;
   logic [VREG_ADDRESS_WIDTH-1:0] w_w_address;
   data_packet_t                  w_vd_old;
   data_packet_t                  w_v0;

   assign w_r_valid   = (r_state == StROnly) || (r_state == StBoth);
   assign w_w_valid   = (r_state == StWOnly) || (r_state == StBoth);
   assign w_r_address = VREG_ADDRESS_WIDTH'(r_r_entry.address);
   assign w_w_address = VREG_ADDRESS_WIDTH'(r_w_entry.address);

   vector_write_back_hazard_detect #(
      .VREG_ADDRESS_WIDTH(VREG_ADDRESS_WIDTH)
   ) u_hazard_detect (
      .i_r_valid  (w_r_valid),
      .i_r_address(w_r_address),
      .i_w_valid  (w_w_valid),
      .i_w_address(w_w_address),
      .o_vd_hazard(w_vd_hazard),
      .o_v0_hazard(w_v0_hazard)
   );

`ifdef WRITE_BACK_FORWARDING_EN
   data_packet_t r_fwd_data;
   logic         r_fwd_vd;
   logic         r_fwd_v0;

   assign w_stall = 1'b0;

   // The read issued under a hazard returns stale data; the captured write replaces it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fwd_data <= '0;
         r_fwd_vd   <= 1'b0;
         r_fwd_v0   <= 1'b0;
      end else begin
         r_fwd_data <= rf_write_data;
         r_fwd_vd   <= w_vd_hazard;
         r_fwd_v0   <= w_v0_hazard;
      end
   end

   assign w_vd_old = r_fwd_vd ? r_fwd_data : rf_read_vd_old;
   assign w_v0     = r_fwd_v0 ? r_fwd_data : rf_read_v0;
`else
   assign w_stall  = w_vd_hazard | w_v0_hazard;
   assign w_vd_old = rf_read_vd_old;
   assign w_v0     = rf_read_v0;
`endif

   assign w_advance      = w_r_valid & ~w_stall;
   assign execute_ready  = ~reset & (~w_r_valid | w_advance);
   assign w_accept       = execute_valid & execute_ready;
   assign w_r_valid_next = w_accept | (w_r_valid & ~w_advance);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= StEmpty;
         r_r_entry <= '0;
         r_w_entry <= '0;
      end else begin
         case ({w_r_valid_next, w_advance})
            2'b00:   r_state <= StEmpty;
            2'b10:   r_state <= StROnly;
            2'b01:   r_state <= StWOnly;
            default: r_state <= StBoth;
         endcase
         if (w_accept) begin
            r_r_entry.vd_new  <= execute_vd_new;
            r_r_entry.control <= execute_control;
            r_r_entry.address <= DEFAULT_VREG_ADDRESS_WIDTH'(execute_vd_address);
         end
         if (w_advance) begin
            r_w_entry <= r_r_entry;
         end
      end
   end

   // Strobes and payloads are forced to zero during reset so a flushed entry never writes.
   assign w_r_active = w_r_valid & ~w_stall & ~reset;
   assign w_w_active = w_w_valid & ~reset;

   assign rf_read_enable   = w_r_active;
   assign rf_read_address  = w_r_active ? w_r_address : '0;

   assign mask_control     = w_w_active ? r_w_entry.control : '0;
   assign mask_vd_new      = w_w_active ? r_w_entry.vd_new : '0;
   assign mask_vd_old      = w_w_active ? w_vd_old : '0;
   assign mask_v0          = w_w_active ? w_v0 : '0;

   assign rf_write_enable  = w_w_active;
   assign rf_write_address = w_w_active ? w_w_address : '0;
   assign rf_write_data    = w_w_active ? mask_vd : '0;

endmodule

// File: tb/tb_vector_write_back_controller.sv
// Directed plus random bench for vector_write_back_controller with a register-file
// model, a stand-in masking unit and a sequential-semantics reference model.
module tb_vector_write_back_controller;
   import dragonfang_pkg::*;

   localparam int unsigned AW = DEFAULT_VREG_ADDRESS_WIDTH;
`ifdef WRITE_BACK_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      data_packet_t  data;
      data_packet_t  old;
      data_packet_t  v0;
      int            wcyc;
   } exp_t;

   logic               clock = 1'b0;
   logic               reset;
   logic               execute_valid;
   logic               execute_ready;
   data_packet_t       execute_vd_new;
   write_back_vector_t execute_control;
   logic [AW-1:0]      execute_vd_address;
   logic               rf_read_enable;
   logic [AW-1:0]      rf_read_address;
   data_packet_t       rd_old;
   data_packet_t       rd_v0;
   write_back_vector_t mask_control;
   data_packet_t       mask_v0;
   data_packet_t       mask_vd_old;
   data_packet_t       mask_vd_new;
   data_packet_t       mask_vd;
   logic               rf_write_enable;
   logic [AW-1:0]      rf_write_address;
   data_packet_t       rf_write_data;

   data_packet_t rf_mem   [32];
   data_packet_t model_rf [32];
   exp_t         exp_q[$];
   logic         preload = 1'b1;
   int           cyc = 0;
   int           n_vec = 0;
   int           n_err = 0;
   bit           have_prev = 1'b0;
   int           prev_wr = 0;
   logic [AW-1:0] prev_vd = '0;

   always #5 clock = ~clock;

   function automatic data_packet_t init_val(input int i);
      data_packet_t p;
      p.tag  = 8'(i);
      p.data = {32'(i) * 32'h9E37_79B9, 32'(i) * 32'h85EB_CA6B + 32'h1234_5678};
      if (i == 3) p.data = 64'hAAAA_AAAA_AAAA_AAAA;
      return p;
   endfunction

   // Stand-in masking unit: active lanes take new data, inactive lanes keep old.
   function automatic data_packet_t merge(input write_back_vector_t c, input data_packet_t v0,
                                          input data_packet_t old, input data_packet_t nw);
      data_packet_t r;
      r.tag  = nw.tag;
      r.data = c.vm ? nw.data : ((nw.data & v0.data) | (old.data & ~v0.data));
      return r;
   endfunction

   function automatic write_back_vector_t mk_ctl(input logic vm);
      write_back_vector_t c;
      c.bit_mode = 2'd3;
      c.vm       = vm;
      c.vta      = 1'b0;
      c.vma      = 1'b0;
      return c;
   endfunction

   assign mask_vd = merge(mask_control, mask_v0, mask_vd_old, mask_vd_new);

   // Register file: a read during a same-index write returns the old value.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (preload) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
         rd_old <= '0;
         rd_v0  <= '0;
      end else begin
         if (rf_read_enable) begin
            rd_old <= rf_mem[rf_read_address];
            rd_v0  <= rf_mem[0];
         end
         if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_data;
      end
   end

   vector_write_back_controller #(
      .VREG_ADDRESS_WIDTH(AW)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .execute_valid     (execute_valid),
      .execute_ready     (execute_ready),
      .execute_vd_new    (execute_vd_new),
      .execute_control   (execute_control),
      .execute_vd_address(execute_vd_address),
      .rf_read_enable    (rf_read_enable),
      .rf_read_address   (rf_read_address),
      .rf_read_vd_old    (rd_old),
      .rf_read_v0        (rd_v0),
      .mask_control      (mask_control),
      .mask_v0           (mask_v0),
      .mask_vd_old       (mask_vd_old),
      .mask_vd_new       (mask_vd_new),
      .mask_vd           (mask_vd),
      .rf_write_enable   (rf_write_enable),
      .rf_write_address  (rf_write_address),
      .rf_write_data     (rf_write_data)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
      n_vec++;
      assert (obs === req) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, req);
      end
   endtask

   // Sequential semantics: each op merges against the state left by all earlier ops.
   // Write lands two cycles after acceptance, one more if it must wait for the
   // previous op's write to the same register or to v0 (stall build only).
   task automatic push_model(input data_packet_t nw, input write_back_vector_t ctl,
                             input logic [AW-1:0] vd);
      exp_t e;
      int   rd;
      rd = cyc + 1;
      if (!FWD && have_prev && prev_wr == rd && (vd == prev_vd || prev_vd == '0)) rd++;
      e.addr = vd;
      e.old  = model_rf[vd];
      e.v0   = model_rf[0];
      e.data = merge(ctl, e.v0, e.old, nw);
      e.wcyc = rd + 1;
      model_rf[vd] = e.data;
      exp_q.push_back(e);
      have_prev = 1'b1;
      prev_wr   = rd + 1;
      prev_vd   = vd;
   endtask

   task automatic step(input logic rst, input logic vld, input data_packet_t nw,
                       input write_back_vector_t ctl, input logic [AW-1:0] vd,
                       input bit keep, output bit acc);
      exp_t e;
      @(negedge clock);
      reset              = rst;
      execute_valid      = vld;
      execute_vd_new     = nw;
      execute_control    = ctl;
      execute_vd_address = vd;
      #1;
      if (rst) have_prev = 1'b0;
      if (exp_q.size() == 0) begin
         chk("unexpected_write", 128'(rf_write_enable), 128'(0));
      end else if (rf_write_enable === 1'b1 || cyc >= exp_q[0].wcyc) begin
         e = exp_q.pop_front();
         chk("wr_cycle", 128'(cyc), 128'(e.wcyc));
         chk("wr_enable", 128'(rf_write_enable), 128'(1));
         chk("wr_addr", 128'(rf_write_address), 128'(e.addr));
         chk("wr_data", 128'(rf_write_data), 128'(e.data));
         chk("mask_vd_old", 128'(mask_vd_old), 128'(e.old));
         chk("mask_v0", 128'(mask_v0), 128'(e.v0));
      end
      acc = vld && (execute_ready === 1'b1);
      if (acc && keep) push_model(nw, ctl, vd);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, a);
   endtask

   task automatic send(input logic [AW-1:0] vd, input data_packet_t nw,
                       input write_back_vector_t ctl, input bit keep, output int acc_cyc);
      bit acc;
      acc     = 1'b0;
      acc_cyc = -1;
      for (int i = 0; i < 8 && !acc; i++) begin
         step(1'b0, 1'b1, nw, ctl, vd, keep, acc);
         if (acc) acc_cyc = cyc;
      end
      chk("accept_timeout", 128'(acc), 128'(1));
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ready"}, 128'(execute_ready), 128'(0));
      chk({tag, "_rd_en"}, 128'(rf_read_enable), 128'(0));
      chk({tag, "_rd_addr"}, 128'(rf_read_address), 128'(0));
      chk({tag, "_wr_addr"}, 128'(rf_write_address), 128'(0));
      chk({tag, "_wr_data"}, 128'(rf_write_data), 128'(0));
      chk({tag, "_mask_new"}, 128'(mask_vd_new), 128'(0));
      chk({tag, "_mask_ctl"}, 128'(mask_control), 128'(0));
   endtask

   initial begin
      bit            acc;
      bit            pend;
      int            a1, a2, a3;
      data_packet_t  p_nw;
      write_back_vector_t p_ctl;
      logic [AW-1:0] p_vd;

      for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);

      // Reset state
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, acc);
      step(1'b1, 1'b1, '0, '0, '0, 1'b0, acc);
      chk_quiet("reset");
      preload = 1'b0;
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc);
      chk("ready_after_reset", 128'(execute_ready), 128'(1));

      // Single op: vd=3 over old 0xAAAA...
      send(5'd3, {8'h11, 64'h1111_1111_1111_1111}, mk_ctl(1'b1), 1'b1, a1);
      idle(1);
      chk("single_rd_cycle", 128'(cyc), 128'(a1 + 1));
      chk("single_rd_en", 128'(rf_read_enable), 128'(1));
      chk("single_rd_addr", 128'(rf_read_address), 128'(3));
      idle(3);

      // Back-to-back independent ops
      send(5'd1, {8'h21, 64'h0123_4567_89AB_CDEF}, mk_ctl(1'b1), 1'b1, a1);
      send(5'd2, {8'h22, 64'hFEDC_BA98_7654_3210}, mk_ctl(1'b0), 1'b1, a2);
      send(5'd4, {8'h24, 64'h5555_0000_FFFF_AAAA}, mk_ctl(1'b1), 1'b1, a3);
      chk("b2b_accept_2", 128'(a2), 128'(a1 + 1));
      chk("b2b_accept_3", 128'(a3), 128'(a2 + 1));
      idle(4);

      // vd RAW hazard
      send(5'd5, {8'h51, 64'h0F0F_0F0F_3C3C_3C3C}, mk_ctl(1'b0), 1'b1, a1);
      send(5'd5, {8'h52, 64'hFFFF_0000_1234_9876}, mk_ctl(1'b0), 1'b1, a2);
      idle(1);
      chk("raw_ready", 128'(execute_ready), 128'(FWD ? 1 : 0));
      idle(4);

      // v0 hazard
      send(5'd0, {8'h60, 64'h0000_0000_0000_000F}, mk_ctl(1'b1), 1'b1, a1);
      send(5'd7, {8'h67, 64'hCAFE_BABE_DEAD_BEEF}, mk_ctl(1'b0), 1'b1, a2);
      idle(4);

      // Reset with both stages full: entries discarded, nothing written
      send(5'd9, {8'h99, 64'h9999_9999_9999_9999}, mk_ctl(1'b1), 1'b0, a1);
      send(5'd10, {8'hAA, 64'h1010_1010_1010_1010}, mk_ctl(1'b1), 1'b0, a2);
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, acc);
      chk("midreset_wr_en", 128'(rf_write_enable), 128'(0));
      chk_quiet("midreset");
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc);
      chk("midreset_ready_after", 128'(execute_ready), 128'(1));
      idle(3);

      // Random traffic; producer holds an op until it is accepted
      pend  = 1'b0;
      p_nw  = '0;
      p_ctl = '0;
      p_vd  = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            pend      = 1'b1;
            p_vd      = AW'($urandom_range(0, 7));
            p_nw.tag  = 8'($urandom);
            p_nw.data = {$urandom, $urandom};
            p_ctl     = mk_ctl(1'($urandom_range(0, 1)));
         end
         step(1'b0, pend, p_nw, p_ctl, p_vd, 1'b1, acc);
         if (acc) pend = 1'b0;
      end
      idle(8);
      chk("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vector_write_back_controller.md
# vector_write_back_controller

Sequential write-back stage for the vector pipeline. Accepts execute results through a valid/ready handshake, reads the old destination register and `v0` from the vector register file, and presents aligned operands to the combinational `vector_masking_unit_v2`. It then writes the merged result back to the register file. The pipeline is two stages, with read-after-write hazard handling between back-to-back results.

## Interface
Parameters:
- `VREG_ADDRESS_WIDTH`, default 5: vector register address width (32 registers).

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `execute_valid`  in  1  execute result valid
- `execute_ready`  out  1  stage can accept a result this cycle
- `execute_vd_new`  in  `data_packet_t`  new result (tag + 64-bit data)
- `execute_control`  in  `write_back_vector_t`  `bit_mode`, `vm`, `vta`, `vma`
- `execute_vd_address`  in  `VREG_ADDRESS_WIDTH`  destination register index
- `rf_read_enable`  out  1  register-file read strobe
- `rf_read_address`  out  `VREG_ADDRESS_WIDTH`  vd_old read index
- `rf_read_vd_old`  in  `data_packet_t`  vd_old data, valid one cycle after strobe
- `rf_read_v0`  in  `data_packet_t`  v0 data, same timing as vd_old
- `mask_control`  out  `write_back_vector_t`  to masking unit
- `mask_v0`, `mask_vd_old`, `mask_vd_new`  out  `data_packet_t`  to masking unit
- `mask_vd`  in  `data_packet_t`  merged result from masking unit
- `rf_write_enable`  out  1  register-file write strobe
- `rf_write_address`  out  `VREG_ADDRESS_WIDTH`  write index
- `rf_write_data`  out  `data_packet_t`  equals `mask_vd`

## Operation
- Stage R (read): holds one accepted entry (`vd_new`, control, address) and asserts `rf_read_enable`/`rf_read_address` in the cycle after acceptance.
- Stage W (write): holds one entry plus the returned vd_old/v0 data.
  - Drives `mask_*` outputs.
  - Asserts `rf_write_enable` for exactly one cycle with `rf_write_data = mask_vd`.
- The stage is always able to drain, so there is no downstream backpressure. R advances to W every cycle unless stalled by a hazard (see Configuration).
- `execute_ready` = R empty OR R advancing this cycle.
- Transfer occurs on `execute_valid && execute_ready`.
- Per-stage valid bits, with states EMPTY, R_ONLY, W_ONLY and BOTH. Transitions follow from accept and advance.
- Register-file contract: a read during a write to the same index returns the OLD value.
- Hazard condition: the entry in R reads index A while W writes A in the same cycle. It also applies when W writes index 0 and R needs `v0`; every masked op needs `v0`, so a write to `v0` always hazards.
- All 64 data bits and the tag pass through unchanged; the controller never modifies data.

## Timing
- Reset values:
  - `execute_ready` = 0 while `reset` is high, and 1 in the first cycle after release.
  - All strobes = 0.
  - All address/data/mask outputs = 0.
  - Both valid bits cleared.
- Reset mid-operation discards both entries; no write is issued.
- Latency: accepted in cycle t, read strobe in t+1, write strobe in t+2.
- Throughput: one result per cycle when no hazard.
- An `execute_valid` not accepted must be held stable by the producer; the controller samples only on transfer.

## Configuration
- `WRITE_BACK_FORWARDING_EN` defined:
  - On a hazard, W's `rf_write_data` and the hazard kind (vd and/or v0) are registered.
  - In the next cycle, the registered data replaces `rf_read_vd_old` and/or `rf_read_v0`.
  - No stall; throughput stays 1/cycle.
- Undefined:
  - On a hazard, R does not issue its read.
  - R stalls one cycle and re-issues after the write completes.
  - `execute_ready` = 0 during the stall.

## Structure
- Package `dragonfang_pkg`:
  - `data_packet_t` and `write_back_vector_t` (existing).
  - New `write_back_entry_t` (`vd_new`, control, address).
  - `VREG_ADDRESS_WIDTH` default constant.
- One natural sub-module: `vector_write_back_hazard_detect`. It compares the R and W addresses and outputs `vd_hazard` and `v0_hazard`.
- The masking unit stays external, connected at the parent level.

## Test plan
- Single op:
  - Stimulus: accept vd=3, `vd_new` data 0x1111…, `vm=1`, vd_old 0xAAAA….
  - Required: read strobe at t+1 (address 3), write strobe at t+2 (address 3), data = `mask_vd`.
- Back-to-back independent ops:
  - Stimulus: vd=1, 2, 4 on three consecutive cycles.
  - Required: `execute_ready` stays 1; three consecutive writes with addresses 1, 2, 4.
- vd RAW hazard:
  - Stimulus: ops to vd=5 then vd=5.
  - Required: second op's `mask_vd_old` equals the first op's written data.
  - With `WRITE_BACK_FORWARDING_EN`: writes at t+2 and t+3.
  - Without: writes at t+2 and t+4, with `execute_ready` low for one cycle.
- v0 hazard:
  - Stimulus: op writing v0 = 0x…0F, then a masked op to vd=7.
  - Required: second op's `mask_v0` = 0x…0F.
- Reset mid-flight:
  - Stimulus: assert `reset` for one cycle with both stages full.
  - Required: no `rf_write_enable`; all outputs 0; `execute_ready` = 1 the following cycle.
